// File: rtl/incr9_seq_pkg.sv
// ---------------------------------------------------------------------------
// incr9_seq_pkg
// Shared types for the 9-bit sequence-number generator.
//   SEQ_W   : sequence width (9)
//   seq_t   : sequence value type
//   state_t : control FSM states (IDLE, RUN, DONE)
//   grp_inc : 3-bit group increment used by the carry-select incrementer
// Optional feature macro used elsewhere in the slice: INCR9_SEQ_WRAPCNT_EN
// ---------------------------------------------------------------------------
package incr9_seq_pkg;

    localparam int SEQ_W = 9;

    typedef logic [SEQ_W-1:0] seq_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [2:0] grp_inc(input logic [2:0] g);
        return g + 3'd1;
    endfunction

endpackage

// File: rtl/incr9_seq_if.sv
// ---------------------------------------------------------------------------
// incr9_seq_if
// Valid/ready output bus of the sequence generator.
//   out_valid : sequence value presented
//   out_ready : consumer accepts the value
//   out_seq   : current sequence number
//   out_last  : out_seq equals the terminal value (qualified by out_valid)
//   out_wrap  : one-cycle pulse after a terminal-value transfer
//   wrap_cnt  : saturating wrap counter (only with INCR9_SEQ_WRAPCNT_EN)
// Modports: master (generator side), slave (consumer side).
// ---------------------------------------------------------------------------
interface incr9_seq_if;
    import incr9_seq_pkg::*;

    logic       out_valid;
    logic       out_ready;
    seq_t       out_seq;
    logic       out_last;
    logic       out_wrap;
`ifdef INCR9_SEQ_WRAPCNT_EN
    logic [7:0] wrap_cnt;

    modport master (
        output out_valid, out_seq, out_last, out_wrap, wrap_cnt,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_seq, out_last, out_wrap, wrap_cnt,
        output out_ready
    );
`else
    modport master (
        output out_valid, out_seq, out_last, out_wrap,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_seq, out_last, out_wrap,
        output out_ready
    );
`endif

endinterface

// File: rtl/incr9_seq_next.sv
// ---------------------------------------------------------------------------
// incr9_seq_next
// Combinational next-value logic for the sequence register.
//   seq    : current sequence value
//   nxt    : (seq == MAX) ? 0 : seq + 1  (mod 2^9)
//   at_max : seq equals MAX
// The +1 is a 3x3-bit carry-select: every 3-bit group is incremented in
// parallel and the group all-ones terms of the lower groups pick between
// the incremented and the unchanged copy, so there is no 9-bit ripple.
// ---------------------------------------------------------------------------
module incr9_seq_next
    import incr9_seq_pkg::*;
#(
    parameter seq_t MAX = 9'h1FF
) (
    input  seq_t seq,
    output seq_t nxt,
    output logic at_max
);

    logic [2:0] g0, g1, g2;
    logic       a0, a1, a2;
    seq_t       inc;

    assign g0 = seq[2:0];
    assign g1 = seq[5:3];
    assign g2 = seq[8:6];

    assign a0 = &g0;
    assign a1 = &g1;
    assign a2 = &g2;

    assign inc = {(a0 & a1) ? grp_inc(g2) : g2,
                  a0        ? grp_inc(g1) : g1,
                  grp_inc(g0)};

    generate
        if (MAX == 9'h1FF) begin : g_full_range
            // Terminal value is all-ones: the carry-out is the wrap, and the
            // incrementer already rolls over to zero.
            assign at_max = a0 & a1 & a2;
            assign nxt    = inc;
        end else begin : g_cmp_range
            // Values loaded above MAX still count up and roll over at 1FF
            // because inc is naturally mod 2^9.
            assign at_max = (seq == MAX);
            assign nxt    = at_max ? '0 : inc;
        end
    endgenerate

endmodule

// File: rtl/incr9_seq.sv
// ---------------------------------------------------------------------------
// incr9_seq
// 9-bit sequence-number generator with a valid/ready output.
// Parameters:
//   INIT : value loaded into the sequence register on reset
//   MAX  : terminal value; the value after MAX is 0
//   WRAP : 1 = keep running after MAX, 0 = stop in DONE after MAX transfers
// Ports:
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   start, stop : run control (stop wins when both are high)
//   load_valid  : load load_value into the sequence register
//   load_value  : value to load
//   out_if      : incr9_seq_if.master output bus
// Optional feature: define INCR9_SEQ_WRAPCNT_EN to add the saturating
// 8-bit wrap counter (out_if.wrap_cnt).
// ---------------------------------------------------------------------------
module incr9_seq
    import incr9_seq_pkg::*;
#(
    parameter seq_t INIT = 9'h000,
    parameter seq_t MAX  = 9'h1FF,
    parameter bit   WRAP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        load_valid,
    input  seq_t        load_value,
    incr9_seq_if.master out_if
);

    state_t state, state_nxt;
    seq_t   seq_p0, seq_nxt;
    seq_t   inc_val;
    logic   at_max;
    logic   vld_p0;
    logic   xfer;
    logic   wrap_evt;
    logic   out_wrap_p0;

    incr9_seq_next #(.MAX(MAX)) u_next (
        .seq    (seq_p0),
        .nxt    (inc_val),
        .at_max (at_max)
    );

    assign vld_p0 = (state == RUN);
    assign xfer   = vld_p0 & out_if.out_ready;
    // A load overrides the advance, so the register never goes through 0.
    assign wrap_evt = xfer & at_max & ~load_valid;

    always_comb begin
        state_nxt = state;
        seq_nxt   = seq_p0;

        if (load_valid) begin
            seq_nxt = load_value;
        end else if (xfer) begin
            seq_nxt = inc_val;
        end

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (wrap_evt && !WRAP) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start && !stop) begin
                    state_nxt = RUN;
                end else if (load_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: state, sequence value and wrap pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seq_p0      <= INIT;
            out_wrap_p0 <= 1'b0;
        end else begin
            state       <= state_nxt;
            seq_p0      <= seq_nxt;
            out_wrap_p0 <= wrap_evt;
        end
    end

    assign out_if.out_valid = vld_p0;
    assign out_if.out_seq   = seq_p0;
    assign out_if.out_last  = vld_p0 & at_max;
    assign out_if.out_wrap  = out_wrap_p0;

`ifdef INCR9_SEQ_WRAPCNT_EN
    logic [7:0] wrap_cnt_p0;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || load_valid) begin
            wrap_cnt_p0 <= '0;
        end else if (wrap_evt) begin
            wrap_cnt_p0 <= sat_inc8(wrap_cnt_p0);
        end
    end

    assign out_if.wrap_cnt = wrap_cnt_p0;
`endif

endmodule

// File: tb/tb_incr9_seq.sv
// ---------------------------------------------------------------------------
// tb_incr9_seq
// Bench for incr9_seq. Three instances share the control inputs:
//   u_a : INIT=0, MAX=1FF, WRAP=1  (table-driven vectors)
//   u_b : INIT=0, MAX=10,  WRAP=0  (terminate / resume sequence)
//   u_c : INIT=0, MAX=3,   WRAP=1  (long wrap run, reset mid-run)
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_incr9_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       load_valid;
    logic [8:0] load_value;
    logic       rdy;

    int n_chk;
    int n_pass;

    incr9_seq_if if_a ();
    incr9_seq_if if_b ();
    incr9_seq_if if_c ();

    assign if_a.out_ready = rdy;
    assign if_b.out_ready = rdy;
    assign if_c.out_ready = rdy;

    incr9_seq #(.INIT(9'h000), .MAX(9'h1FF), .WRAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .load_valid(load_valid), .load_value(load_value), .out_if(if_a)
    );

    incr9_seq #(.INIT(9'h000), .MAX(9'd10), .WRAP(1'b0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .load_valid(load_valid), .load_value(load_value), .out_if(if_b)
    );

    incr9_seq #(.INIT(9'h000), .MAX(9'd3), .WRAP(1'b1)) u_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .load_valid(load_valid), .load_value(load_value), .out_if(if_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       load_valid;
        logic [8:0] load_value;
        logic       rdy;
        logic       valid;
        logic [8:0] seq;
        logic       last;
        logic       wrap;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic s, st, lv, input logic [8:0] v,
                                input logic r, input logic ev,
                                input logic [8:0] es, input logic el, ew);
        vec_t t;
        t.start = s;  t.stop = st; t.load_valid = lv; t.load_value = v;
        t.rdy = r;    t.valid = ev; t.seq = es; t.last = el; t.wrap = ew;
        return t;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step(input logic s, st, lv, input logic [8:0] v, input logic r);
        start = s; stop = st; load_valid = lv; load_value = v; rdy = r;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; load_valid = 1'b0; load_value = '0; rdy = 1'b0;

        //           s  st lv value   r  | valid seq    last wrap
        vecs[0]  = mk(1, 0, 0, 9'h000, 1,   0, 9'h000, 0, 0);
        vecs[1]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h000, 0, 0);
        vecs[2]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h001, 0, 0);
        vecs[3]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h002, 0, 0);
        vecs[4]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h003, 0, 0);
        vecs[5]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h004, 0, 0);
        vecs[6]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h005, 0, 0);
        vecs[7]  = mk(0, 0, 0, 9'h000, 0,   1, 9'h006, 0, 0);
        vecs[8]  = mk(0, 0, 0, 9'h000, 0,   1, 9'h006, 0, 0);
        vecs[9]  = mk(0, 0, 0, 9'h000, 1,   1, 9'h006, 0, 0);
        vecs[10] = mk(0, 0, 0, 9'h000, 1,   1, 9'h007, 0, 0);
        vecs[11] = mk(0, 0, 1, 9'h0AB, 1,   1, 9'h008, 0, 0);
        vecs[12] = mk(0, 0, 0, 9'h000, 0,   1, 9'h0AB, 0, 0);
        vecs[13] = mk(0, 0, 1, 9'h1FE, 0,   1, 9'h0AB, 0, 0);
        vecs[14] = mk(0, 0, 0, 9'h000, 1,   1, 9'h1FE, 0, 0);
        vecs[15] = mk(0, 0, 0, 9'h000, 1,   1, 9'h1FF, 1, 0);
        vecs[16] = mk(0, 0, 0, 9'h000, 1,   1, 9'h000, 0, 1);
        vecs[17] = mk(0, 0, 0, 9'h000, 0,   1, 9'h001, 0, 0);
        vecs[18] = mk(1, 1, 0, 9'h000, 1,   1, 9'h001, 0, 0);
        vecs[19] = mk(0, 0, 0, 9'h000, 1,   0, 9'h002, 0, 0);
        vecs[20] = mk(0, 0, 0, 9'h000, 1,   0, 9'h002, 0, 0);
        vecs[21] = mk(1, 0, 1, 9'h1FF, 0,   0, 9'h002, 0, 0);
        vecs[22] = mk(0, 0, 0, 9'h000, 0,   1, 9'h1FF, 1, 0);
        vecs[23] = mk(0, 0, 0, 9'h000, 1,   1, 9'h1FF, 1, 0);
        vecs[24] = mk(0, 1, 0, 9'h000, 0,   1, 9'h000, 0, 1);
        vecs[25] = mk(0, 0, 0, 9'h000, 0,   0, 9'h000, 0, 0);

        // Reset state of all instances
        repeat (2) @(negedge clk);
        chk("rst_a_valid", {8'd0, if_a.out_valid}, 9'd0);
        chk("rst_a_seq",   if_a.out_seq,           9'h000);
        chk("rst_a_last",  {8'd0, if_a.out_last},  9'd0);
        chk("rst_a_wrap",  {8'd0, if_a.out_wrap},  9'd0);
        chk("rst_b_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("rst_c_seq",   if_c.out_seq,           9'h000);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("rst_c_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd0);
`endif
        rst = 1'b0;

        // Table-driven vectors on u_a
        for (int i = 0; i < 26; i++) begin
            step(vecs[i].start, vecs[i].stop, vecs[i].load_valid,
                 vecs[i].load_value, vecs[i].rdy);
            chk($sformatf("row%0d_valid", i), {8'd0, if_a.out_valid}, {8'd0, vecs[i].valid});
            chk($sformatf("row%0d_seq", i),   if_a.out_seq,           vecs[i].seq);
            chk($sformatf("row%0d_last", i),  {8'd0, if_a.out_last},  {8'd0, vecs[i].last});
            chk($sformatf("row%0d_wrap", i),  {8'd0, if_a.out_wrap},  {8'd0, vecs[i].wrap});
            @(negedge clk);
        end

        // u_b: terminate at MAX=10, resume, loads above MAX
        step(0, 0, 0, 9'h000, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 1, 9'd9, 1);
        chk("b_idle_valid", {8'd0, if_b.out_valid}, 9'd0);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        chk("b_seq9_valid", {8'd0, if_b.out_valid}, 9'd1);
        chk("b_seq9",       if_b.out_seq,           9'd9);
        chk("b_seq9_last",  {8'd0, if_b.out_last},  9'd0);
        @(negedge clk);
        chk("b_seq10",      if_b.out_seq,           9'd10);
        chk("b_seq10_last", {8'd0, if_b.out_last},  9'd1);
        @(negedge clk);
        chk("b_done_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("b_done_seq",   if_b.out_seq,           9'd0);
        chk("b_done_last",  {8'd0, if_b.out_last},  9'd0);
        chk("b_done_wrap",  {8'd0, if_b.out_wrap},  9'd1);
        @(negedge clk);
        step(1, 0, 0, 9'h000, 1);
        chk("b_done_hold_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("b_done_hold_seq",   if_b.out_seq,           9'd0);
        chk("b_done_hold_wrap",  {8'd0, if_b.out_wrap},  9'd0);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        chk("b_resume_valid", {8'd0, if_b.out_valid}, 9'd1);
        chk("b_resume_seq0",  if_b.out_seq,           9'd0);
        @(negedge clk);
        step(0, 1, 1, 9'h1FE, 1);
        chk("b_resume_seq1", if_b.out_seq, 9'd1);
        @(negedge clk);
        step(1, 0, 0, 9'h000, 1);
        chk("b_stop_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("b_load_1fe",   if_b.out_seq,           9'h1FE);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        chk("b_over_1fe",  if_b.out_seq,          9'h1FE);
        chk("b_over_last", {8'd0, if_b.out_last}, 9'd0);
        @(negedge clk);
        chk("b_over_1ff",  if_b.out_seq, 9'h1FF);
        @(negedge clk);
        chk("b_over_000",       if_b.out_seq,           9'h000);
        chk("b_over_000_valid", {8'd0, if_b.out_valid}, 9'd1);
        chk("b_over_000_wrap",  {8'd0, if_b.out_wrap},  9'd0);
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("b_run_seq%0d", k), if_b.out_seq, 9'(k));
            chk($sformatf("b_run_last%0d", k), {8'd0, if_b.out_last}, {8'd0, (k == 10)});
            @(negedge clk);
        end
        step(0, 0, 1, 9'd7, 1);
        chk("b_done2_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("b_done2_seq",   if_b.out_seq,           9'd0);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        chk("b_done_load_valid", {8'd0, if_b.out_valid}, 9'd0);
        chk("b_done_load_seq",   if_b.out_seq,           9'd7);
        @(negedge clk);

        // u_c: MAX=3 long run, wrap counter saturation, reset mid-run
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 9'h000, 1);
        chk("c_idle_valid", {8'd0, if_c.out_valid}, 9'd0);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        for (int k = 0; k < 42; k++) @(negedge clk);
        chk("c_k42_valid", {8'd0, if_c.out_valid}, 9'd1);
        chk("c_k42_seq",   if_c.out_seq,           9'd2);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("c_k42_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd10);
`endif
        for (int k = 0; k < 1000; k++) @(negedge clk);
        chk("c_k1042_seq", if_c.out_seq, 9'd2);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("c_sat_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd255);
`endif
        step(0, 0, 1, 9'd1, 1);
        @(negedge clk);
        step(0, 0, 0, 9'h000, 1);
        chk("c_load_seq", if_c.out_seq, 9'd1);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("c_load_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd0);
`endif
        for (int k = 0; k < 5; k++) @(negedge clk);
        chk("c_k5_seq",  if_c.out_seq,          9'd2);
        chk("c_k5_wrap", {8'd0, if_c.out_wrap}, 9'd0);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("c_k5_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd1);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("c_midrst_valid", {8'd0, if_c.out_valid}, 9'd0);
        chk("c_midrst_seq",   if_c.out_seq,           9'd0);
        chk("c_midrst_last",  {8'd0, if_c.out_last},  9'd0);
        chk("c_midrst_wrap",  {8'd0, if_c.out_wrap},  9'd0);
        chk("c_midrst_a_valid", {8'd0, if_a.out_valid}, 9'd0);
        chk("c_midrst_b_valid", {8'd0, if_b.out_valid}, 9'd0);
`ifdef INCR9_SEQ_WRAPCNT_EN
        chk("c_midrst_wrap_cnt", {1'b0, if_c.wrap_cnt}, 9'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
